msrv32_dbus_ahb_master: RTL
===========================

Name: msrv32_dbus_ahb_master

Overview:
Data-side bus master between the msrv32 core's data-memory port and an AHB-Lite slave fabric. It accepts one core load/store request at a time and runs single AHB-Lite transfers with separate address and data phases. It absorbs slave wait states and ERROR responses, and returns read data plus ready/response to the core's data_hready/hresp/dmdata inputs.

Parameters:
TIMEOUT_CYCLES, 16, max DATA-phase wait cycles before forced error abort (used only with DBUS_TIMEOUT_EN)
TO_CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYCLES

Ports:
ms_riscv32_mp_clk_in  in  1  core clock
ms_riscv32_mp_rst_in  in  1  synchronous, active-high reset
core_dmaddr_in  in  32  core data address
core_dmdata_in  in  32  core write data, already lane-aligned
core_dmwr_req_in  in  1  1=store, 0=load
core_dmwr_mask_in  in  4  store byte-lane mask
core_htrans_in  in  2  2'b10=request, 2'b00=idle
core_dmdata_out  out  32  load data to core
core_hready_out  out  1  core data_hready
core_hresp_out  out  1  core hresp; valid only when core_hready_out=1
haddr_out  out  32  AHB HADDR
hwrite_out  out  1  AHB HWRITE
hsize_out  out  3  AHB HSIZE
htrans_out  out  2  AHB HTRANS
hwdata_out  out  32  AHB HWDATA
hrdata_in  in  32  AHB HRDATA
hready_in  in  1  AHB HREADY
hresp_in  in  1  AHB HRESP, 1=ERROR

Behaviour:
- One clock, ms_riscv32_mp_clk_in. Reset is synchronous and active-high on ms_riscv32_mp_rst_in.
- FSM states: IDLE, ADDR, DATA, RESP.
- Reset values:
  - state=IDLE, htrans_out=2'b00, haddr_out=0, hwrite_out=0, hsize_out=3'b010, hwdata_out=0.
  - core_dmdata_out=0, core_hready_out=1, core_hresp_out=0.
- Accept: a request is accepted when core_htrans_in==2'b10 in IDLE or RESP. Addr, data, write and mask are latched. core_htrans_in values 2'b01 and 2'b11 are treated as 2'b00.
- Store size/offset decode from mask:
  - 1111: word, offset 0
  - 0011: half, offset 0
  - 1100: half, offset 2
  - 0001/0010/0100/1000: byte, offset 0/1/2/3
  - any other value, including 0000: illegal. No bus transfer; next state RESP with error.
- Store drive: haddr_out={addr[31:2],offset}.
- Load drive: hsize_out=3'b010 and haddr_out={addr[31:2],2'b00}. The core's load unit extracts the bytes.
- ADDR (1 cycle): htrans_out=2'b10 (NONSEQ); haddr/hwrite/hsize driven from registers; core_hready_out=0. Next state DATA unconditionally. The fabric has no other master, so HREADY is high at entry.
- DATA:
  - htrans_out=2'b00; haddr/hwrite/hsize held; hwdata_out=latched store data for the whole phase; core_hready_out=0.
  - hready_in=0, hresp_in=0: wait.
  - hready_in=0, hresp_in=1: first ERROR cycle. Stay, keep htrans=IDLE.
  - hready_in=1: transfer complete. Latch hrdata_in into core_dmdata_out (loads only; stores leave it unchanged) and latch error=hresp_in. Next state RESP.
- RESP (1 cycle): core_hready_out=1, core_hresp_out=error flag. A new request may be accepted in this cycle; otherwise go to IDLE, where core_hresp_out=0.
- Latency: zero-wait load returns 3 cycles after acceptance (ADDR, DATA, RESP). Each HREADY-low cycle adds one.
- Core contract: the core holds its request signals stable while core_hready_out=0. The block ignores core_htrans_in in ADDR and DATA.
- Reset mid-transfer: the next edge forces IDLE and htrans_out=IDLE. The pending transfer is dropped and no response is given.

Optional Feature:
DBUS_TIMEOUT_EN
- Defined:
  - A TO_CNT_W counter clears on entry to DATA and increments each DATA cycle with hready_in=0.
  - When it reaches TIMEOUT_CYCLES with hready_in still 0, the FSM goes to RESP with error=1 and core_dmdata_out unchanged.
  - The counter saturates and is reset by ms_riscv32_mp_rst_in.
- Not defined: no counter; DATA waits indefinitely.

Test Plan:
- Load, zero wait: req addr=0x0000_1006, wr=0 -> ADDR cycle haddr=0x0000_1004, hsize=010, htrans=10. Slave hrdata=0xDEADBEEF -> RESP cycle core_dmdata_out=0xDEADBEEF, core_hready_out=1, core_hresp_out=0, 3 cycles after accept.
- Byte store with 2 wait states: addr=0x200, mask=0100, data=0x00AB0000 -> haddr=0x202, hsize=000, hwrite=1; hwdata=0x00AB0000 held through 3 DATA cycles; core_hready_out=0 until RESP.
- Slave ERROR: two-cycle response (hresp=1/hready=0, then hresp=1/hready=1) -> htrans=00 throughout DATA; RESP has core_hresp_out=1, core_hready_out=1.
- Illegal mask 0101 store -> htrans_out stays 00 every cycle; next cycle RESP with core_hresp_out=1.
- Back-to-back: new request asserted during RESP -> ADDR for the second transfer on the very next cycle, no IDLE gap. Reset asserted during DATA -> next cycle IDLE, htrans=00, core_hready_out=1, core_hresp_out=0.
- With DBUS_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave hready stuck 0 -> RESP with core_hresp_out=1 after 4 DATA wait cycles; without the macro, still in DATA after 100 cycles.

Source files
------------

// File: rtl/msrv32_dbus_ahb_master.sv
// msrv32 data-port to AHB-Lite single-transfer master (IDLE/ADDR/DATA/RESP).
// Optional DATA-phase timeout abort is enabled by defining DBUS_TIMEOUT_EN.
module msrv32_dbus_ahb_master #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TO_CNT_W       = 5
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] core_dmaddr_in,
  input  logic [31:0] core_dmdata_in,
  input  logic        core_dmwr_req_in,
  input  logic [3:0]  core_dmwr_mask_in,
  input  logic [1:0]  core_htrans_in,
  output logic [31:0] core_dmdata_out,
  output logic        core_hready_out,
  output logic        core_hresp_out,
  output logic [31:0] haddr_out,
  output logic        hwrite_out,
  output logic [2:0]  hsize_out,
  output logic [1:0]  htrans_out,
  output logic [31:0] hwdata_out,
  input  logic [31:0] hrdata_in,
  input  logic        hready_in,
  input  logic        hresp_in
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES >= (1 << TO_CNT_W)) begin : g_bad_timeout_param
    $error("TO_CNT_W too narrow for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e      r_state, w_state_nxt;
  logic [31:0] r_haddr, w_haddr_nxt;
  logic        r_hwrite, w_hwrite_nxt;
  logic [2:0]  r_hsize, w_hsize_nxt;
  logic [31:0] r_hwdata, w_hwdata_nxt;
  logic [31:0] r_rdata, w_rdata_nxt;
  logic        r_err, w_err_nxt;

  logic        w_req;
  logic        w_st_legal;
  logic [2:0]  w_st_size;
  logic [1:0]  w_st_off;
  logic        w_to_hit;
  logic        w_unused_addr;

  // Stores take their size/offset from the lane mask; the address low bits are ignored.
  assign w_unused_addr = ^core_dmaddr_in[1:0];
  assign w_req         = (core_htrans_in == 2'b10);

  always_comb begin
    w_st_legal = 1'b1;
    w_st_size  = 3'b010;
    w_st_off   = 2'd0;
    unique case (core_dmwr_mask_in)
      4'b1111: begin w_st_size = 3'b010; w_st_off = 2'd0; end
      4'b0011: begin w_st_size = 3'b001; w_st_off = 2'd0; end
      4'b1100: begin w_st_size = 3'b001; w_st_off = 2'd2; end
      4'b0001: begin w_st_size = 3'b000; w_st_off = 2'd0; end
      4'b0010: begin w_st_size = 3'b000; w_st_off = 2'd1; end
      4'b0100: begin w_st_size = 3'b000; w_st_off = 2'd2; end
      4'b1000: begin w_st_size = 3'b000; w_st_off = 2'd3; end
      default: w_st_legal = 1'b0;
    endcase
  end

`ifdef DBUS_TIMEOUT_EN
  localparam logic [TO_CNT_W-1:0] ToLast = TO_CNT_W'(TIMEOUT_CYCLES - 1);

  logic [TO_CNT_W-1:0] r_to_cnt, w_to_cnt_nxt;

  // Fires on the TIMEOUT_CYCLES-th consecutive HREADY-low DATA cycle.
  assign w_to_hit = !hready_in && (r_to_cnt >= ToLast);

  always_comb begin
    w_to_cnt_nxt = r_to_cnt;
    if (r_state == StAddr) begin
      w_to_cnt_nxt = '0;
    end else if (r_state == StData && !hready_in && r_to_cnt != '1) begin
      w_to_cnt_nxt = r_to_cnt + TO_CNT_W'(1);
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_to_cnt <= '0;
    end else begin
      r_to_cnt <= w_to_cnt_nxt;
    end
  end
`else
  assign w_to_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_haddr_nxt  = r_haddr;
    w_hwrite_nxt = r_hwrite;
    w_hsize_nxt  = r_hsize;
    w_hwdata_nxt = r_hwdata;
    w_rdata_nxt  = r_rdata;
    w_err_nxt    = r_err;
    unique case (r_state)
      StIdle, StResp: begin
        if (!w_req) begin
          w_state_nxt = StIdle;
        end else if (core_dmwr_req_in && !w_st_legal) begin
          // Illegal store mask: answer with an error without touching the bus.
          w_state_nxt = StResp;
          w_err_nxt   = 1'b1;
        end else begin
          w_state_nxt  = StAddr;
          w_hwrite_nxt = core_dmwr_req_in;
          w_hwdata_nxt = core_dmdata_in;
          w_err_nxt    = 1'b0;
          if (core_dmwr_req_in) begin
            w_haddr_nxt = {core_dmaddr_in[31:2], w_st_off};
            w_hsize_nxt = w_st_size;
          end else begin
            w_haddr_nxt = {core_dmaddr_in[31:2], 2'b00};
            w_hsize_nxt = 3'b010;
          end
        end
      end
      StAddr: w_state_nxt = StData;
      StData: begin
        if (hready_in) begin
          w_state_nxt = StResp;
          w_err_nxt   = hresp_in;
          if (!r_hwrite) begin
            w_rdata_nxt = hrdata_in;
          end
        end else if (w_to_hit) begin
          w_state_nxt = StResp;
          w_err_nxt   = 1'b1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      r_state  <= StIdle;
      r_haddr  <= '0;
      r_hwrite <= 1'b0;
      r_hsize  <= 3'b010;
      r_hwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_haddr  <= w_haddr_nxt;
      r_hwrite <= w_hwrite_nxt;
      r_hsize  <= w_hsize_nxt;
      r_hwdata <= w_hwdata_nxt;
      r_rdata  <= w_rdata_nxt;
      r_err    <= w_err_nxt;
    end
  end

  assign htrans_out      = (r_state == StAddr) ? 2'b10 : 2'b00;
  assign haddr_out       = r_haddr;
  assign hwrite_out      = r_hwrite;
  assign hsize_out       = r_hsize;
  assign hwdata_out      = r_hwdata;
  assign core_dmdata_out = r_rdata;
  assign core_hready_out = (r_state == StIdle) || (r_state == StResp);
  assign core_hresp_out  = (r_state == StResp) && r_err;

endmodule
